mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before abort; legal range 1..255.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 ex_mem_memread / ex_mem_memwrite  in  1 each  load / store request from EX_MEM.
REQ-005 ex_mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-006 ex_mem_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-007 ex_mem_addr / ex_mem_wdata  in  32 each  byte address / store data (rt value).
REQ-008 dmem_req, dmem_we  out  1 each  memory request / write strobe.
REQ-009 dmem_addr  out  32  word address, bits [1:0] = 00; dmem_be  out  4  byte enables; dmem_wdata  out  32  lane-aligned store data.
REQ-010 dmem_ack  in  1; dmem_rdata  in  32  memory completion and read word.
REQ-011 mem_stall  out  1  freezes IF..EX_MEM while high; MEM_MemData  out  32  extended load result.
REQ-012 mem_done, mem_timeout, mem_addr_error  out  1 each  single-cycle status pulses.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-014 IDLE: when memread or memwrite is high and the access is legal, the block SHALL register dmem_req=1, dmem_addr, dmem_be, dmem_we, dmem_wdata and enter WAIT on the next edge.
REQ-015 When memwrite and memread are both high, the access SHALL be a write; the read is ignored.
REQ-016 mem_stall SHALL be combinationally high in IDLE when a legal request is present, and high throughout WAIT; low in DONE.
REQ-017 WAIT: dmem_req SHALL stay high and its outputs stable until dmem_ack is sampled high; dmem_ack is ignored outside WAIT.
REQ-018 On ack: drop dmem_req on that edge, capture extended read data (0 for writes) into MEM_MemData, enter DONE.
REQ-019 DONE SHALL last exactly one cycle with mem_done=1, then return to IDLE; minimum latency request-to-DONE is 2 cycles.
REQ-020 MEM_MemData SHALL hold its value until the next completed access.
REQ-021 Byte lanes SHALL be little-endian: byte at offset n uses be=1<<n, data replicated to all lanes; half uses be=0011 (addr[1]=0) or 1100; word uses be=1111.
REQ-022 Loads SHALL extract the addressed byte/half and extend to 32 bits per ex_mem_unsigned.
REQ-023 A WAIT counter SHALL increment each WAIT cycle; on reaching TIMEOUT without ack, drop dmem_req, set MEM_MemData=0, pulse mem_timeout, enter DONE.
REQ-024 Ack arriving in the same cycle the counter reaches TIMEOUT SHALL be treated as a normal completion (no timeout).

Reset
REQ-025 reset low SHALL immediately force state IDLE, counter 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, MEM_MemData=0, all pulses 0, mem_stall=0.
REQ-026 Reset mid-WAIT SHALL abandon the access; a later dmem_ack is ignored.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no request, assert no stall, and pulse mem_addr_error for one cycle with MEM_MemData=0.
REQ-028 Macro undefined: low address bits beyond the access size SHALL be ignored (forced alignment) and mem_addr_error SHALL be tied 0.

Verification
REQ-029 Word load addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF -> dmem_be=1111, stall 4 cycles, MEM_MemData=0xDEADBEEF, mem_done one pulse.
REQ-030 Signed byte load addr 0x103, rdata 0x80123456 -> be=1000, MEM_MemData=0xFFFFFF80; unsigned -> 0x00000080.
REQ-031 Half store addr 0x202, wdata 0x0000ABCD -> dmem_we=1, be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200.
REQ-032 TIMEOUT=4, no ack -> dmem_req drops after 4 WAIT cycles, mem_timeout pulse, MEM_MemData=0, back to IDLE.
REQ-033 reset low during WAIT, ack next cycle -> dmem_req=0 at once, no mem_done, state IDLE.
REQ-034 With MEM_ALIGN_CHECK_EN, word load addr 0x101 -> no dmem_req, mem_stall 0, mem_addr_error one pulse.

Source files
------------

// File: rtl/mem_access.sv
// Load/store unit to a ready/ack data memory: issues 1 registered request, stalls until ack or TIMEOUT, then 1-cycle DONE (min 2 cycles).
// Stall holds EX_MEM while busy; MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of forcing alignment.
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEM_MemData,
    output logic        mem_done,
    output logic        mem_timeout,
    output logic        mem_addr_error
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [8:0] TMO = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d, sz_q, sz_d;
    logic        uns_q, uns_d, tmo_q, tmo_d, aerr_q, aerr_d;

    logic        is_req, legal, bad_align;
    logic [3:0]  be_c;
    logic [31:0] lane_wdata_c;

    assign is_req = ex_mem_memread | ex_mem_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (ex_mem_size == 2'b01 && ex_mem_addr[0]) ||
                        (ex_mem_size[1] && ex_mem_addr[1:0] != 2'b00);
    assign legal      = is_req & ~misaligned;
    assign bad_align  = is_req & misaligned;
`else
    assign legal      = is_req;
    assign bad_align  = 1'b0;
`endif

    always_comb begin
        be_c         = 4'b1111;
        lane_wdata_c = ex_mem_wdata;
        if (!ex_mem_size[1]) begin
            if (ex_mem_size[0]) begin
                be_c         = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata_c = {2{ex_mem_wdata[15:0]}};
            end else begin
                be_c         = 4'b0001 << ex_mem_addr[1:0];
                lane_wdata_c = {4{ex_mem_wdata[7:0]}};
            end
        end
    end

    // Extraction uses the offset/size captured at issue, so the result does not depend on EX_MEM staying frozen.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        if (sz[1])
            return w;
        else if (sz[0])
            return uns ? {16'h0000, h} : {{16{h[15]}}, h};
        else
            return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        off_d     = off_q;
        sz_d      = sz_q;
        uns_d     = uns_q;
        data_d    = data_q;
        tmo_d     = 1'b0;
        aerr_d    = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = ex_mem_memwrite;
                    addr_d    = {ex_mem_addr[31:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = lane_wdata_c;
                    off_d     = ex_mem_addr[1:0];
                    sz_d      = ex_mem_size;
                    uns_d     = ex_mem_unsigned;
                    cnt_d     = 8'd0;
                    state_d   = WAIT;
                end else if (bad_align) begin
                    aerr_d = 1'b1;
                    data_d = 32'h0;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    data_d  = we_q ? 32'h0 : load_ext(dmem_rdata, off_q, sz_q, uns_q);
                    state_d = DONE;
                end else if ({1'b0, cnt_q} + 9'd1 == TMO) begin
                    req_d   = 1'b0;
                    data_d  = 32'h0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
            sz_q    <= 2'b00;
            uns_q   <= 1'b0;
            data_q  <= 32'h0;
            tmo_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            sz_q    <= sz_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            aerr_q  <= aerr_d;
        end
    end

    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign MEM_MemData    = data_q;
    assign mem_done       = (state_q == DONE);
    assign mem_timeout    = tmo_q;
    assign mem_addr_error = aerr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT=4): per-cycle expectations derived from the access timeline and lane rules.
module tb_mem_access;

    localparam int TMO = 4;

    logic        clock = 1'b0, reset = 1'b0;
    logic        memread = 1'b0, memwrite = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, mem_stall, mem_done, mem_timeout, mem_addr_error;
    logic [31:0] dmem_addr, dmem_wdata, MEM_MemData;
    logic [3:0]  dmem_be;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_memread(memread), .ex_mem_memwrite(memwrite),
        .ex_mem_size(size), .ex_mem_unsigned(uns),
        .ex_mem_addr(addr), .ex_mem_wdata(wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(rdata),
        .mem_stall(mem_stall), .MEM_MemData(MEM_MemData),
        .mem_done(mem_done), .mem_timeout(mem_timeout), .mem_addr_error(mem_addr_error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;
    logic        chk_en = 1'b0;
    logic        e_req = 0, e_we = 0, e_stall = 0, e_done = 0, e_tmo = 0, e_aerr = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_data = '0, m_data = '0;
    logic [3:0]  e_be = '0;
    int          obs_stall, obs_done;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz >= 2) return 4'hF;
        if (sz == 1) return (a & 2) != 0 ? 4'hC : 4'h3;
        return 4'(1 << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz >= 2) return w;
        if (sz == 1) return 32'(w[15:0]) * 32'h00010001;
        return 32'(w[7:0]) * 32'h01010101;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] w);
        int unsigned v;
        if (sz >= 2) return w;
        if (sz == 0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!u && v >= 128) v = v - 256;
        end else begin
            v = (w >> (8 * (a & 2))) & 32'hFFFF;
            if (!u && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
            chk("mem_done", {31'b0, mem_done}, {31'b0, e_done});
            chk("mem_timeout", {31'b0, mem_timeout}, {31'b0, e_tmo});
            chk("mem_addr_error", {31'b0, mem_addr_error}, {31'b0, e_aerr});
            chk("MEM_MemData", MEM_MemData, e_data);
            if (e_req) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
        end
    end

    task automatic idle_exp();
        e_req = 0; e_stall = 0; e_done = 0; e_tmo = 0; e_aerr = 0; e_data = m_data;
    endtask

    // ack_at: WAIT cycle (1-based) carrying dmem_ack; 0 means memory never answers.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd_word,
                          input int ack_at);
        bit acked = 0;
        memread = rd; memwrite = wr; size = sz; uns = u; addr = a; wdata = wd; rdata = rd_word;
        dmem_ack = 0;
        idle_exp();
        e_stall = 1;
        e_we = wr; e_addr = a & ~32'h3; e_be = m_be(sz, a); e_wdata = m_wdata(sz, wd);
        obs_stall = 0; obs_done = 0;
        #3 obs_stall += int'(mem_stall);
        @(posedge clock); #1;
        for (int k = 1; k <= TMO; k++) begin
            e_req = 1;
            dmem_ack = (k == ack_at);
            #3 obs_stall += int'(mem_stall);
            if (k == 1) begin
                obs_be = dmem_be; obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_we = dmem_we;
            end
            @(posedge clock); #1;
            if (k == ack_at) begin
                acked = 1;
                break;
            end
        end
        dmem_ack = 0; memread = 0; memwrite = 0;
        m_data = !acked ? 32'h0 : (wr ? 32'h0 : m_load(sz, u, a, rd_word));
        idle_exp();
        e_done = 1; e_tmo = !acked;
        #3 begin obs_done += int'(mem_done); obs_stall += int'(mem_stall); end
        @(posedge clock); #1;
        idle_exp();
        #3 obs_done += int'(mem_done);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_we", {31'b0, dmem_we}, 32'h0);
        chk("rst_be", {28'b0, dmem_be}, 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_data", MEM_MemData, 32'h0);
        chk("rst_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_pulses", {29'b0, mem_done, mem_timeout, mem_addr_error}, 32'h0);
        @(posedge clock); #1 reset = 1;
        idle_exp();
        chk_en = 1;
        repeat (2) @(posedge clock);
        #1;

        // Word load, ack in third WAIT cycle
        access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        chk("w_load_stall_cycles", 32'(obs_stall), 32'd4);
        chk("w_load_done_pulses", 32'(obs_done), 32'd1);
        chk("w_load_be", {28'b0, obs_be}, 32'hF);
        chk("w_load_data", MEM_MemData, 32'hDEADBEEF);

        // Byte loads at offset 3, minimum latency
        access(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80123456, 1);
        chk("sb_load_be", {28'b0, obs_be}, 32'h8);
        chk("sb_load_data", MEM_MemData, 32'hFFFFFF80);
        chk("sb_load_stall_cycles", 32'(obs_stall), 32'd2);
        access(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80123456, 1);
        chk("ub_load_data", MEM_MemData, 32'h00000080);

        // Half store to upper half
        access(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h12345678, 2);
        chk("h_store_we", {31'b0, obs_we}, 32'h1);
        chk("h_store_be", {28'b0, obs_be}, 32'hC);
        chk("h_store_wdata", obs_wdata, 32'hABCDABCD);
        chk("h_store_addr", obs_addr, 32'h200);
        chk("h_store_data", MEM_MemData, 32'h0);

        // Signed half load, ack on the same cycle the counter hits TIMEOUT
        access(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h80017FFF, TMO);
        chk("h_load_at_limit", MEM_MemData, 32'hFFFF8001);

        // No ack: timeout
        access(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h11111111, 0);
        chk("timeout_data", MEM_MemData, 32'h0);
        chk("timeout_stall_cycles", 32'(obs_stall), 32'd5);

        // Read and write together resolve to a write
        access(1, 0, 2'b10, 1, 32'h504, 32'h0, 32'h0BADF00D, 2);
        access(1, 1, 2'b10, 0, 32'h500, 32'h12345678, 32'hCAFEF00D, 1);
        chk("rw_we", {31'b0, obs_we}, 32'h1);
        chk("rw_data", MEM_MemData, 32'h0);

        // Size 11 behaves as word; byte store lane replication
        access(1, 0, 2'b11, 1, 32'h600, 32'h0, 32'h87654321, 2);
        chk("sz11_data", MEM_MemData, 32'h87654321);
        access(0, 1, 2'b00, 0, 32'h301, 32'hFFFFFF5A, 32'h0, 1);
        chk("b_store_be", {28'b0, obs_be}, 32'h2);
        chk("b_store_wdata", obs_wdata, 32'h5A5A5A5A);
        access(1, 0, 2'b01, 1, 32'h106, 32'h0, 32'h9ABC1234, 1);
        chk("uh_load_data", MEM_MemData, 32'h00009ABC);

        // Misaligned word load at 0x101
`ifdef MEM_ALIGN_CHECK_EN
        memread = 1; memwrite = 0; size = 2'b10; uns = 0; addr = 32'h101;
        idle_exp();
        @(posedge clock); #1;
        memread = 0;
        m_data = 32'h0;
        idle_exp();
        e_aerr = 1;
        #3 chk("align_err_pulse", {31'b0, mem_addr_error}, 32'h1);
        @(posedge clock); #1;
        idle_exp();
        @(posedge clock); #1;
`else
        access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h13572468, 1);
        chk("forced_align_addr", obs_addr, 32'h100);
        chk("forced_align_data", MEM_MemData, 32'h13572468);
`endif

        // Reset in the middle of WAIT; the late ack must be ignored
        memread = 1; memwrite = 0; size = 2'b10; uns = 0; addr = 32'h700; rdata = 32'h76543210;
        idle_exp();
        e_stall = 1; e_we = 0; e_addr = 32'h700; e_be = 4'hF;
        @(posedge clock); #1;
        e_req = 1;
        @(posedge clock); #1;
        #2 chk_en = 0;
        reset = 0;
        memread = 0;
        #1;
        chk("rst_mid_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_mid_stall", {31'b0, mem_stall}, 32'h0);
        chk("rst_mid_data", MEM_MemData, 32'h0);
        @(posedge clock); #1;
        reset = 1;
        dmem_ack = 1;
        m_data = 32'h0;
        idle_exp();
        chk_en = 1;
        @(posedge clock); #1;
        dmem_ack = 0;
        #3 chk("rst_no_done", {31'b0, mem_done}, 32'h0);
        @(posedge clock); #1;

        // Normal operation after the abandoned access
        access(1, 0, 2'b00, 1, 32'h800, 32'h0, 32'h000000C3, 1);
        chk("post_rst_data", MEM_MemData, 32'h000000C3);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
